// File: rtl/out_port_fifo_if.sv
// Handshake bundle between the processor output port, the FIFO and its consumer.
// The slave modport is the FIFO; the master modport is the producer/consumer side.
interface out_port_fifo_if #(
    parameter int WIDTH = 16,
    parameter int PTR_W = 2
);
    logic             wr_en;
    logic [WIDTH-1:0] write_out;
    logic             full;
    logic [PTR_W:0]   count;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overflow;

    modport master (
        output wr_en, write_out, dout_ready,
        input  full, count, dout, dout_valid, overflow
    );

    modport slave (
        input  wr_en, write_out, dout_ready,
        output full, count, dout, dout_valid, overflow
    );
endinterface

// File: rtl/out_port_fifo.sv
// Show-ahead FIFO capturing processor output writes and presenting them to a
// valid/ready consumer; a write into a full FIFO with no pop is dropped and flagged.
module out_port_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic            clock,
    input logic            rst,
    out_port_fifo_if.slave port
);
    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             overflow_r;
    logic             full_s;
    logic             valid_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;

    assign full_s  = (count_r == DEPTH_C);
    assign valid_s = (count_r != {(PTR_W+1){1'b0}});
    assign pop_s   = valid_s & port.dout_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_s  = port.wr_en & (~full_s | pop_s);
    assign drop_s  = port.wr_en & full_s & ~pop_s;

    // Storage array; deliberately not reset.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= port.write_out;
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {(PTR_W+1){1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Head word is shown ahead of the pop and held at zero while empty.
    always_comb begin
        port.dout = {WIDTH{1'b0}};
        if (valid_s) begin
            port.dout = mem_r[rd_ptr_r];
        end else begin
            port.dout = {WIDTH{1'b0}};
        end
    end

    assign port.full       = full_s;
    assign port.count      = count_r;
    assign port.dout_valid = valid_s;
    assign port.overflow   = overflow_r;
endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo: stimulus queues expected words, a negedge
// monitor compares every accepted dout against the queue head.
module tb_out_port_fifo;
    logic clock;
    logic rst;
    int   n_vec;
    int   n_bad;
    logic [15:0] exp_q[$];

    out_port_fifo_if #(.WIDTH(16), .PTR_W(2)) dif ();

    out_port_fifo #(.WIDTH(16), .DEPTH(4), .PTR_W(2)) dut (
        .clock (clock),
        .rst   (rst),
        .port  (dif.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the next rising edge.
    task automatic step(input logic we, input logic [15:0] d, input logic rdy);
        dif.wr_en      = we;
        dif.write_out  = d;
        dif.dout_ready = rdy;
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] d);
        exp_q.push_back(d);
        step(1'b1, d, 1'b0);
    endtask

    // Monitor: every accepted word must match the scoreboard head.
    always @(negedge clock) begin
        if (rst && dif.dout_valid && dif.dout_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out: got %0h expected none at %0t", dif.dout, $time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (dif.dout !== e) begin
                    n_bad++;
                    $display("FAIL out_order: got %0h expected %0h at %0t", dif.dout, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        dif.wr_en = 1'b0;
        dif.write_out = 16'h0000;
        dif.dout_ready = 1'b0;

        // 1: reset held for 5 cycles
        repeat (5) @(posedge clock);
        #1;
        rst = 1'b1;
        step(1'b0, 16'h0000, 1'b0);
        chk("rst_count", 32'(dif.count), 32'd0);
        chk("rst_valid", 32'(dif.dout_valid), 32'd0);
        chk("rst_dout", 32'(dif.dout), 32'd0);
        chk("rst_full", 32'(dif.full), 32'd0);
        chk("rst_ovf", 32'(dif.overflow), 32'd0);

        // 2: single word, one-cycle latency, then consumed
        push_exp(16'h000b);
        chk("t2_valid", 32'(dif.dout_valid), 32'd1);
        chk("t2_dout", 32'(dif.dout), 32'h000b);
        chk("t2_count", 32'(dif.count), 32'd1);
        step(1'b0, 16'h0000, 1'b1);
        chk("t2_count_after", 32'(dif.count), 32'd0);
        chk("t2_valid_after", 32'(dif.dout_valid), 32'd0);

        // 3: fill, overflow on the fifth, drain in order
        for (int i = 1; i <= 4; i++) push_exp(16'(i));
        chk("t3_full", 32'(dif.full), 32'd1);
        chk("t3_count", 32'(dif.count), 32'd4);
        step(1'b1, 16'h0005, 1'b0);
        chk("t3_ovf", 32'(dif.overflow), 32'd1);
        chk("t3_count_ovf", 32'(dif.count), 32'd4);
        chk("t3_head", 32'(dif.dout), 32'h0001);
        repeat (4) step(1'b0, 16'h0000, 1'b1);
        chk("t3_drained", 32'(dif.count), 32'd0);
        chk("t3_ovf_sticky", 32'(dif.overflow), 32'd1);

        // clear sticky overflow with a reset pulse
        rst = 1'b0;
        step(1'b0, 16'h0000, 1'b0);
        rst = 1'b1;
        chk("t3_ovf_cleared", 32'(dif.overflow), 32'd0);

        // 4: full FIFO, write and pop in the same cycle
        for (int i = 1; i <= 4; i++) push_exp(16'h0a00 + 16'(i));
        exp_q.push_back(16'h0003);
        step(1'b1, 16'h0003, 1'b1);
        chk("t4_count", 32'(dif.count), 32'd4);
        chk("t4_full", 32'(dif.full), 32'd1);
        chk("t4_ovf", 32'(dif.overflow), 32'd0);
        chk("t4_head", 32'(dif.dout), 32'h0a02);
        repeat (4) step(1'b0, 16'h0000, 1'b1);
        chk("t4_drained", 32'(dif.count), 32'd0);

        // 5: streaming push/pop with pointer wrap
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(16'h0010 + 16'(i));
            step(1'b1, 16'h0010 + 16'(i), 1'b1);
            chk("t5_count", 32'(dif.count), 32'd1);
            chk("t5_dout", 32'(dif.dout), 32'h0010 + 32'(i));
        end
        step(1'b0, 16'h0000, 1'b1);
        chk("t5_drained", 32'(dif.count), 32'd0);

        // 6: asynchronous reset mid-stream discards queued words
        for (int i = 1; i <= 3; i++) push_exp(16'h0030 + 16'(i));
        chk("t6_count_pre", 32'(dif.count), 32'd3);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_valid_async", 32'(dif.dout_valid), 32'd0);
        chk("t6_count_async", 32'(dif.count), 32'd0);
        chk("t6_dout_async", 32'(dif.dout), 32'd0);
        @(posedge clock);
        #1;
        rst = 1'b1;
        push_exp(16'h1234);
        chk("t6_dout", 32'(dif.dout), 32'h1234);
        chk("t6_count", 32'(dif.count), 32'd1);
        step(1'b0, 16'h0000, 1'b1);
        chk("t6_drained", 32'(dif.count), 32'd0);

        step(1'b0, 16'h0000, 1'b0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
